// File: rtl/rgb_pwm_ctrl.sv
// rtl/rgb_pwm_ctrl.sv - three-channel RGB LED PWM controller with warmup sequencing and blink
module rgb_pwm_ctrl #(
   parameter int WARMUP_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs,
   input  logic        we,
   input  logic [7:0]  address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic        rgb0_pwm,
   output logic        rgb1_pwm,
   output logic        rgb2_pwm,
   output logic        rgb_led_en,
   output logic        curr_en
);

   localparam int WC = (WARMUP_CYCLES < 1) ? 1 : WARMUP_CYCLES;
   localparam int WW = $clog2(WC + 1);
   localparam logic [WW-1:0] WARM_LAST = WW'(WC - 1);

   localparam logic [7:0] A_CTRL     = 8'h08;
   localparam logic [7:0] A_STATUS   = 8'h09;
   localparam logic [7:0] A_PRESCALE = 8'h10;
   localparam logic [7:0] A_DUTY0    = 8'h20;
   localparam logic [7:0] A_DUTY1    = 8'h21;
   localparam logic [7:0] A_DUTY2    = 8'h22;
   localparam logic [7:0] A_BLINK    = 8'h30;

   typedef enum logic [1:0] {S_OFF = 2'd0, S_WARMUP = 2'd1, S_ON = 2'd2} state_t;

   state_t          state_q;
   logic [WW-1:0]   warm_cnt_q;
   logic            ctrl_en_q;
   logic [15:0]     prescale_q;
   logic [2:0][7:0] duty_q;
   logic [7:0]      blink_q;

   logic [15:0]     presc_cnt_q, presc_cnt_d;
   logic [7:0]      pwm_cnt_q, pwm_cnt_d;
   logic [7:0]      blink_cnt_q, blink_cnt_d;
   logic            blink_on_q, blink_on_d;
   logic [2:0][7:0] duty_act_q, duty_act_d;
   logic [2:0]      pwm_d;
   logic [31:0]     rdata_d;
   logic            is_on, tick, wrap;

   logic unused_wdata;
   assign unused_wdata = ^write_data[31:16];

   always_comb begin
      is_on       = (state_q == S_ON);
      tick        = is_on && (presc_cnt_q == prescale_q);
      wrap        = tick && (pwm_cnt_q == 8'hFF);
      presc_cnt_d = '0;
      pwm_cnt_d   = '0;
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
      duty_act_d  = duty_q;
      // Outside ON everything idles at a fresh-period state and tracks DUTYn live.
      if (is_on) begin
         presc_cnt_d = tick ? 16'd0 : presc_cnt_q + 16'd1;
         pwm_cnt_d   = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
         duty_act_d  = wrap ? duty_q : duty_act_q;
         blink_cnt_d = blink_cnt_q;
         blink_on_d  = blink_on_q;
         if (blink_q == 8'd0) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
         end else if (wrap) begin
            if (blink_cnt_q >= blink_q) begin
               blink_cnt_d = '0;
               blink_on_d  = ~blink_on_q;
            end else begin
               blink_cnt_d = blink_cnt_q + 8'd1;
            end
         end
      end
      for (int i = 0; i < 3; i++) begin
         pwm_d[i] = is_on && blink_on_q && (pwm_cnt_q < duty_act_q[i]);
      end
   end

   always_comb begin
      rdata_d = '0;
      if (cs && !we) begin
         case (address)
            A_CTRL:     rdata_d = {31'd0, ctrl_en_q};
            A_STATUS:   rdata_d = {30'd0, (state_q == S_WARMUP), is_on};
            A_PRESCALE: rdata_d = {16'd0, prescale_q};
            A_DUTY0:    rdata_d = {24'd0, duty_q[0]};
            A_DUTY1:    rdata_d = {24'd0, duty_q[1]};
            A_DUTY2:    rdata_d = {24'd0, duty_q[2]};
            A_BLINK:    rdata_d = {24'd0, blink_q};
            default:    rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_OFF;
         warm_cnt_q  <= '0;
         ctrl_en_q   <= 1'b0;
         prescale_q  <= '0;
         duty_q      <= '0;
         blink_q     <= '0;
         presc_cnt_q <= '0;
         pwm_cnt_q   <= '0;
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b0;
         duty_act_q  <= '0;
         read_data   <= '0;
         ready       <= 1'b0;
         rgb0_pwm    <= 1'b0;
         rgb1_pwm    <= 1'b0;
         rgb2_pwm    <= 1'b0;
         rgb_led_en  <= 1'b0;
         curr_en     <= 1'b0;
      end else begin
         ready       <= cs;
         read_data   <= rdata_d;
         presc_cnt_q <= presc_cnt_d;
         pwm_cnt_q   <= pwm_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         blink_on_q  <= blink_on_d;
         duty_act_q  <= duty_act_d;
         rgb0_pwm    <= pwm_d[0];
         rgb1_pwm    <= pwm_d[1];
         rgb2_pwm    <= pwm_d[2];

         if (cs && we) begin
            case (address)
               A_CTRL:     ctrl_en_q  <= write_data[0];
               A_PRESCALE: prescale_q <= write_data[15:0];
               A_DUTY0:    duty_q[0]  <= write_data[7:0];
               A_DUTY1:    duty_q[1]  <= write_data[7:0];
               A_DUTY2:    duty_q[2]  <= write_data[7:0];
               A_BLINK:    blink_q    <= write_data[7:0];
               default:    ;
            endcase
         end

         case (state_q)
            S_OFF: begin
               warm_cnt_q <= '0;
               if (ctrl_en_q) begin
                  state_q <= S_WARMUP;
                  curr_en <= 1'b1;
               end
            end
            S_WARMUP: begin
               if (!ctrl_en_q) begin
                  state_q <= S_OFF;
                  curr_en <= 1'b0;
               end else if (warm_cnt_q == WARM_LAST) begin
                  state_q    <= S_ON;
                  rgb_led_en <= 1'b1;
               end else begin
                  warm_cnt_q <= warm_cnt_q + 1'b1;
               end
            end
            S_ON: begin
               if (!ctrl_en_q) begin
                  state_q    <= S_OFF;
                  curr_en    <= 1'b0;
                  rgb_led_en <= 1'b0;
               end
            end
            default: begin
               state_q    <= S_OFF;
               curr_en    <= 1'b0;
               rgb_led_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// tb/tb_rgb_pwm_ctrl.sv - scoreboard bench for rgb_pwm_ctrl with a per-cycle PWM reference model
module tb_rgb_pwm_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cs = 1'b0;
   logic        we = 1'b0;
   logic [7:0]  address = '0;
   logic [31:0] write_data = '0;
   logic [31:0] read_data;
   logic        ready, rgb0_pwm, rgb1_pwm, rgb2_pwm, rgb_led_en, curr_en;

   rgb_pwm_ctrl #(.WARMUP_CYCLES(16)) dut (
      .clk(clk), .reset(reset), .cs(cs), .we(we), .address(address),
      .write_data(write_data), .read_data(read_data), .ready(ready),
      .rgb0_pwm(rgb0_pwm), .rgb1_pwm(rgb1_pwm), .rgb2_pwm(rgb2_pwm),
      .rgb_led_en(rgb_led_en), .curr_en(curr_en)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   // Register model
   logic        m_en = 1'b0;
   logic [15:0] m_presc = '0;
   logic [7:0]  m_duty [3] = '{8'd0, 8'd0, 8'd0};
   logic [7:0]  m_blink = '0;
   logic [1:0]  m_status = '0;

   function automatic logic [31:0] model_read(input logic [7:0] a);
      case (a)
         8'h08:   return {31'd0, m_en};
         8'h09:   return {30'd0, m_status};
         8'h10:   return {16'd0, m_presc};
         8'h20:   return {24'd0, m_duty[0]};
         8'h21:   return {24'd0, m_duty[1]};
         8'h22:   return {24'd0, m_duty[2]};
         8'h30:   return {24'd0, m_blink};
         default: return 32'd0;
      endcase
   endfunction

   function automatic bit is_mapped(input logic [7:0] a);
      return a == 8'h08 || a == 8'h09 || a == 8'h10 || a == 8'h20 ||
             a == 8'h21 || a == 8'h22 || a == 8'h30;
   endfunction

   typedef struct {
      bit          is_rd;
      logic [7:0]  addr;
      logic [31:0] exp;
      int          at;
   } acc_t;
   acc_t sbq[$];
   acc_t mon_e;

   task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
      acc_t e;
      e.is_rd = 1'b0; e.addr = a; e.exp = '0; e.at = cyc + 1;
      sbq.push_back(e);
      cs = 1'b1; we = 1'b1; address = a; write_data = d;
      @(negedge clk);
      cs = 1'b0; we = 1'b0;
      case (a)
         8'h08: m_en = d[0];
         8'h10: m_presc = d[15:0];
         8'h20: m_duty[0] = d[7:0];
         8'h21: m_duty[1] = d[7:0];
         8'h22: m_duty[2] = d[7:0];
         8'h30: m_blink = d[7:0];
         default: ;
      endcase
   endtask

   task automatic bus_read(input logic [7:0] a);
      acc_t e;
      e.is_rd = 1'b1; e.addr = a; e.exp = model_read(a); e.at = cyc + 1;
      sbq.push_back(e);
      cs = 1'b1; we = 1'b0; address = a;
      @(negedge clk);
      cs = 1'b0;
   endtask

   // Bus monitor: every ready pops one access; ready must follow its access by one cycle
   always @(negedge clk) begin
      if (!reset) begin
         if (ready) begin
            if (sbq.size() == 0) begin
               chk("ready_without_access", 32'd1, 32'd0);
            end else begin
               mon_e = sbq.pop_front();
               chk("ready_latency", cyc, mon_e.at);
               if (mon_e.is_rd) chk($sformatf("read_0x%02h", mon_e.addr), read_data, mon_e.exp);
            end
         end else begin
            chk("read_data_idle", read_data, 32'd0);
         end
      end
   end

   logic prev_curr = 1'b0, prev_led = 1'b0;
   int   curr_rise = 0, led_rise = 0;
   always @(negedge clk) begin
      if (curr_en && !prev_curr) curr_rise = cyc;
      if (rgb_led_en && !prev_led) led_rise = cyc;
      prev_curr = curr_en;
      prev_led  = rgb_led_en;
   end

   // PWM reference: position j cycles into ON gives tick count j/(P+1),
   // counter = ticks%256, period = ticks/256, blink phase from period/(B+1).
   bit         arm = 1'b0, chk_en = 1'b0;
   int         on_n = 0;
   logic [7:0] act [3];
   int         pc [16][3];
   always @(negedge clk) begin
      if (arm && !reset) begin
         if (!chk_en) begin
            if (rgb_led_en) begin
               chk_en = 1'b1;
               on_n = 1;
               for (int k = 0; k < 16; k++) for (int i = 0; i < 3; i++) pc[k][i] = 0;
               chk("pwm_at_on_entry", {29'd0, rgb2_pwm, rgb1_pwm, rgb0_pwm}, 32'd0);
            end
         end else begin
            int  j, p1, t, pv, per;
            bit  ph;
            logic [2:0] got;
            j  = on_n - 1;
            p1 = int'(m_presc) + 1;
            if (j % (256 * p1) == 0) for (int i = 0; i < 3; i++) act[i] = m_duty[i];
            t   = j / p1;
            pv  = t % 256;
            per = t / 256;
            ph  = (m_blink == 8'd0) || (((per / (int'(m_blink) + 1)) % 2) == 0);
            got = {rgb2_pwm, rgb1_pwm, rgb0_pwm};
            for (int i = 0; i < 3; i++) begin
               chk($sformatf("rgb%0d_pwm_j%0d", i, j), {31'd0, got[i]},
                   {31'd0, ph && (pv < int'(act[i]))});
               if (got[i] && per < 16) pc[per][i]++;
            end
            chk("enables_in_on", {30'd0, rgb_led_en, curr_en}, 32'd3);
            on_n++;
         end
      end
   end

   task automatic wait_on(input int n);
      int k = 0;
      while (on_n < n && k < 20000) begin
         @(negedge clk);
         k++;
      end
      chk("wait_on_bound", {31'd0, on_n >= n}, 32'd1);
   endtask

   task automatic enable_run();
      int wr_c, k;
      arm = 1'b1; chk_en = 1'b0;
      bus_write(8'h08, 32'd1);
      wr_c = cyc;
      chk("curr_en_before", {31'd0, curr_en}, 32'd0);
      @(negedge clk);
      m_status = 2'b10;
      bus_read(8'h09);
      k = 0;
      while (!rgb_led_en && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("warmup_bound", {31'd0, rgb_led_en}, 32'd1);
      m_status = 2'b01;
      bus_read(8'h09);
      chk("curr_en_latency", curr_rise - wr_c, 32'd1);
      chk("warmup_len", led_rise - curr_rise, 32'd16);
   endtask

   task automatic disable_run();
      arm = 1'b0; chk_en = 1'b0;
      bus_write(8'h08, 32'd0);
      @(negedge clk);
      @(negedge clk);
      chk("outputs_after_disable", {27'd0, rgb0_pwm, rgb1_pwm, rgb2_pwm, rgb_led_en, curr_en}, 32'd0);
      m_status = 2'b00;
      bus_read(8'h09);
   endtask

   task automatic read_all();
      bus_read(8'h08); bus_read(8'h09); bus_read(8'h10); bus_read(8'h20);
      bus_read(8'h21); bus_read(8'h22); bus_read(8'h30);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] targets [7] = '{8'h08, 8'h09, 8'h10, 8'h20, 8'h21, 8'h22, 8'h30};
      logic [7:0] a;
      logic [31:0] d;

      repeat (3) @(negedge clk);
      chk("reset_outputs", {26'd0, rgb0_pwm, rgb1_pwm, rgb2_pwm, rgb_led_en, curr_en, ready}, 32'd0);
      chk("reset_read_data", read_data, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      read_all();

      // Random register traffic while OFF, including unmapped addresses
      for (int n = 0; n < 16; n++) begin
         a = targets[$urandom_range(0, 6)];
         d = $urandom();
         if (a == 8'h08) d[0] = 1'b0;
         bus_write(a, d);
         do a = 8'($urandom_range(0, 255)); while (is_mapped(a));
         bus_write(a, $urandom());
         bus_read(a);
         bus_read(targets[$urandom_range(0, 6)]);
      end
      read_all();

      // Duty 64/0/255, no prescale, no blink
      bus_write(8'h10, 32'd0);
      bus_write(8'h20, 32'd64);
      bus_write(8'h21, 32'd0);
      bus_write(8'h22, 32'd255);
      bus_write(8'h30, 32'd0);
      enable_run();
      wait_on(2 * 256 + 2);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("p%0d_rgb0_high", k), pc[k][0], 32'd64);
         chk($sformatf("p%0d_rgb1_high", k), pc[k][1], 32'd0);
         chk($sformatf("p%0d_rgb2_high", k), pc[k][2], 32'd255);
      end
      disable_run();

      // Re-enable, change DUTY0 mid-period
      enable_run();
      wait_on(100);
      bus_write(8'h20, 32'd128);
      bus_read(8'h20);
      wait_on(2 * 256 + 2);
      chk("dutychg_p0_rgb0", pc[0][0], 32'd64);
      chk("dutychg_p1_rgb0", pc[1][0], 32'd128);
      chk("dutychg_p0_rgb2", pc[0][2], 32'd255);

      // Asynchronous reset between clock edges while ON
      arm = 1'b0; chk_en = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      #1 chk("async_reset_outputs",
             {25'd0, rgb0_pwm, rgb1_pwm, rgb2_pwm, rgb_led_en, curr_en, ready, |read_data}, 32'd0);
      #1 reset = 1'b0;
      m_en = 1'b0; m_presc = '0; m_blink = '0; m_status = '0;
      for (int i = 0; i < 3; i++) m_duty[i] = '0;
      @(negedge clk);
      read_all();

      // Prescale 3, blink 1: two periods on, two off
      bus_write(8'h10, 32'd3);
      bus_write(8'h30, 32'd1);
      bus_write(8'h20, 32'd255);
      bus_write(8'h21, 32'($urandom_range(0, 255)));
      bus_write(8'h22, 32'($urandom_range(0, 255)));
      enable_run();
      wait_on(1500);
      read_all();
      wait_on(5 * 1024 + 2);
      chk("blink_p0_rgb0", pc[0][0], 32'd1020);
      chk("blink_p1_rgb0", pc[1][0], 32'd1020);
      chk("blink_p2_rgb0", pc[2][0], 32'd0);
      chk("blink_p3_rgb0", pc[3][0], 32'd0);
      chk("blink_p4_rgb0", pc[4][0], 32'd1020);
      disable_run();

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", sbq.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rgb_pwm_ctrl.md
RGB_PWM_CTRL -- requirements
Module: rgb_pwm_ctrl

Interface
REQ-001 SHALL have parameter WARMUP_CYCLES, default 16: clk cycles curr_en is held before rgb_led_en asserts.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port cs  input  1  bus access strobe.
REQ-005 SHALL have port we  input  1  write when high with cs; read when low with cs.
REQ-006 SHALL have port address  input  8  register select.
REQ-007 SHALL have port write_data  input  32  write data.
REQ-008 SHALL have port read_data  output  32  read data, valid while ready high.
REQ-009 SHALL have port ready  output  1  access acknowledge.
REQ-010 SHALL have ports rgb0_pwm, rgb1_pwm, rgb2_pwm  output  1 each  per-channel PWM to the LED driver.
REQ-011 SHALL have port rgb_led_en  output  1  LED driver enable.
REQ-012 SHALL have port curr_en  output  1  driver current-reference enable.

Function
REQ-013 SHALL implement registers: 0x08 CTRL (bit0 enable, RW); 0x09 STATUS (bit0 running = state ON, bit1 warming = state WARMUP, RO); 0x10 PRESCALE (16 bits, RW); 0x20/0x21/0x22 DUTY0/1/2 (8 bits, RW); 0x30 BLINK (8 bits, RW); unmapped reads return 0, unmapped writes ignored.
REQ-014 SHALL perform a write on the clk edge where cs=1 and we=1; read_data is zero-extended.
REQ-015 SHALL assert ready exactly one cycle after every cycle with cs=1, for one cycle, with read_data registered in that same cycle; read_data is 0 when ready is low.
REQ-016 SHALL implement state machine OFF, WARMUP, ON: OFF->WARMUP when enable=1; WARMUP->ON after WARMUP_CYCLES cycles in WARMUP; WARMUP->OFF or ON->OFF in the cycle after enable is observed 0.
REQ-017 SHALL drive curr_en=1 in WARMUP and ON, rgb_led_en=1 only in ON; both registered, 0 in OFF.
REQ-018 SHALL run a 16-bit prescaler in ON only, producing one tick when it equals PRESCALE, then restarting at 0 (PRESCALE=0 gives a tick every cycle).
REQ-019 SHALL advance an 8-bit PWM counter by 1 per tick in ON, wrapping 255->0; a period is 256 ticks.
REQ-020 SHALL hold per-channel active duty copies, loaded from DUTYn on each tick where the PWM counter wraps 255->0, and continuously while not in ON; DUTYn writes never alter the current period.
REQ-021 SHALL drive rgbN_pwm registered, 1 iff state ON, blink phase on, and PWM counter < active dutyN; dutyN=0 gives constant 0, dutyN=255 gives 255/256 on.
REQ-022 SHALL, with BLINK=0, force blink phase on and the blink counter to 0.
REQ-023 SHALL, with BLINK=B>0, count PWM period wraps and toggle blink phase when the count reaches B, then restart the count, giving B+1 periods per phase; blink phase starts on at entry to ON.
REQ-024 SHALL, when leaving ON, clear the prescaler, PWM counter, blink counter and blink phase (to on) so re-entry starts a fresh period.
REQ-025 SHALL give a PRESCALE write precedence over the pending prescaler compare, applying it from the next cycle; a write coinciding with a tick does not cancel that tick.

Reset
REQ-026 SHALL, on reset, asynchronously set state OFF, all registers 0, all counters 0, and outputs rgb0_pwm, rgb1_pwm, rgb2_pwm, rgb_led_en, curr_en, ready, read_data to 0.
REQ-027 SHALL, on reset asserted mid-operation, drop all LED outputs to 0 immediately without waiting for a clk edge.

Verification
REQ-028 Reset, write CTRL=1 -> curr_en=1 one cycle later; rgb_led_en=1 exactly 16 cycles after curr_en rose; STATUS reads 0x2 then 0x1.
REQ-029 PRESCALE=0, DUTY0=64, DUTY1=0, DUTY2=255, enabled -> per 256-cycle period rgb0_pwm high 64 cycles, rgb1_pwm never, rgb2_pwm 255 cycles.
REQ-030 DUTY0 changed 64->128 mid-period -> current period still 64 high cycles, next period 128.
REQ-031 PRESCALE=3, BLINK=1, DUTY0=255 -> rgb0_pwm active for 2 periods (2048 cycles), silent for 2 periods, repeating.
REQ-032 CTRL=0 during ON, then CTRL=1 -> all outputs 0 within 2 cycles; re-enable repeats 16-cycle warmup and PWM restarts at counter 0.
REQ-033 reset pulsed between clk edges while ON -> all outputs 0 before the next edge; all registers read 0 afterwards.
